// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter.
// Ownership states of the single-port instruction SRAM.
package imem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_BOOT,
        ARB_RUN,
        ARB_DRAIN,
        ARB_LOAD,
        ARB_RELEASE
    } imem_arb_state_t;

endpackage

// File: rtl/imem_arbiter.sv
// Shares the instruction SRAM between fetch and the loader/debug port,
// stalling and draining the pipeline around every loader ownership period.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DRAIN_CYCLES = 2,
    parameter int MAX_BURST    = 16,
    parameter int BOOT_LOAD    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       fetch_pc,
    input  logic              fetch_en,
    output logic              fsm_sel,
    output logic              fetch_stall,
    output logic              fetch_misalign,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    input  logic              ldr_done,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [31:0]       ldr_rdata,
    output logic              mem_csn,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam imem_arb_state_t RESET_STATE =
        (BOOT_LOAD != 0) ? ARB_BOOT : ARB_RELEASE;

    imem_arb_state_t state, state_nxt;
    logic [3:0]      drain_cnt, drain_nxt;
    logic [7:0]      burst_cnt, burst_nxt;
    logic            run_first;
    logic [ADDR_W-1:0] fetch_addr;
    logic            unused_pc;

    assign fetch_addr = fetch_pc[ADDR_W+1:2];
    assign unused_pc  = ^fetch_pc[31:ADDR_W+2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RESET_STATE;
            drain_cnt  <= '0;
            burst_cnt  <= '0;
            run_first  <= 1'b0;
            ldr_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_nxt;
            burst_cnt  <= burst_nxt;
            run_first  <= (state == ARB_RELEASE);
            ldr_rvalid <= ldr_gnt & ~ldr_we;
        end
    end

    always_comb begin
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        burst_nxt   = burst_cnt;
        fsm_sel     = 1'b1;
        fetch_stall = 1'b1;
        ldr_gnt     = 1'b0;
        mem_csn     = 1'b1;
        mem_wen     = 1'b1;
        mem_addr    = '0;
        mem_din     = '0;
        case (state)
            ARB_BOOT, ARB_LOAD: begin
                ldr_gnt  = ldr_req;
                mem_csn  = ~ldr_req;
                mem_wen  = ~(ldr_req & ldr_we);
                mem_addr = ldr_addr;
                mem_din  = ldr_wdata;
                if (state == ARB_LOAD && ldr_req) begin
                    burst_nxt = burst_cnt + 8'd1;
                    if (burst_cnt == BURST_LAST)
                        state_nxt = ARB_RELEASE;
                end
                if (ldr_done)
                    state_nxt = ARB_RELEASE;
            end
            ARB_RUN: begin
                fsm_sel     = 1'b0;
                fetch_stall = 1'b0;
                mem_csn     = ~fetch_en;
                mem_addr    = fetch_addr;
                if (!run_first && ldr_req) begin
                    state_nxt = ARB_DRAIN;
                    drain_nxt = DRAIN_INIT;
                end
            end
            ARB_DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    state_nxt = ARB_LOAD;
                    burst_nxt = '0;
                end else begin
                    drain_nxt = drain_cnt - 4'd1;
                end
            end
            ARB_RELEASE: begin
                // re-read the held PC so RUN presents it without a skip
                mem_csn   = 1'b0;
                mem_addr  = fetch_addr;
                state_nxt = ARB_RUN;
            end
            default: state_nxt = RESET_STATE;
        endcase
        if (RST) begin
            fsm_sel     = 1'b1;
            fetch_stall = 1'b1;
            ldr_gnt     = 1'b0;
            mem_csn     = 1'b1;
            mem_wen     = 1'b1;
            mem_addr    = '0;
            mem_din     = '0;
        end
    end

    assign fetch_misalign = (state == ARB_RUN) & fetch_en & (|fetch_pc[1:0]);
    assign ldr_rdata      = mem_dout;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: SRAM model plus a shadow-memory reference
// and arithmetic timing expectations for drain, burst and release.
module tb_imem_arbiter;

    logic        CLK;
    logic        RST;
    logic [31:0] fetch_pc;
    logic        fetch_en;
    logic        fsm_sel;
    logic        fetch_stall;
    logic        fetch_misalign;
    logic        ldr_req;
    logic        ldr_we;
    logic [9:0]  ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_done;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic        mem_csn;
    logic        mem_wen;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_chk;
    int n_fail;

    logic [31:0] sram   [1024];
    logic [31:0] shadow [1024];
    logic [9:0]  ba [10];
    logic [31:0] bd [10];

    imem_arbiter #(
        .ADDR_W(10),
        .DRAIN_CYCLES(2),
        .MAX_BURST(4),
        .BOOT_LOAD(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .fetch_pc(fetch_pc),
        .fetch_en(fetch_en),
        .fsm_sel(fsm_sel),
        .fetch_stall(fetch_stall),
        .fetch_misalign(fetch_misalign),
        .ldr_req(ldr_req),
        .ldr_we(ldr_we),
        .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata),
        .ldr_done(ldr_done),
        .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid),
        .ldr_rdata(ldr_rdata),
        .mem_csn(mem_csn),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!mem_csn) begin
            if (!mem_wen)
                sram[mem_addr] <= mem_din;
            mem_dout <= sram[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic return_to_run();
        bit seen;
        seen = 1'b0;
        ldr_req  = 1'b0;
        ldr_done = 1'b1;
        @(negedge CLK);
        next_cycle();
        ldr_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (!fetch_stall && !fsm_sel) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL return_to_run: fetch never resumed");
        end
        next_cycle();
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 10'd7;
        ldr_wdata = $urandom;
        fetch_en  = 1'b1;
        fetch_pc  = $urandom;
        @(negedge CLK);
        n_chk++;
        if ({fsm_sel, fetch_stall, ldr_gnt, ldr_rvalid, mem_csn, mem_wen}
            !== 6'b110011) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 110011",
                {fsm_sel, fetch_stall, ldr_gnt, ldr_rvalid, mem_csn, mem_wen});
        end
        n_chk++;
        if (mem_addr !== 10'd0 || mem_din !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h din %h want 0 0",
                mem_addr, mem_din);
        end
        ldr_req  = 1'b0;
        fetch_pc = 32'd0;
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_boot_load();
        int grants;
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            ldr_req   = 1'b1;
            ldr_we    = 1'b1;
            ldr_addr  = 10'(i);
            ldr_wdata = 32'h0000_0013;
            @(negedge CLK);
            n_chk++;
            if ({ldr_gnt, mem_csn, mem_wen} !== 3'b100 || mem_addr !== 10'(i)) begin
                n_fail++;
                $display("FAIL boot_write: got gnt/csn/wen %b addr %0d want 100 %0d",
                    {ldr_gnt, mem_csn, mem_wen}, mem_addr, i);
            end
            if (ldr_gnt) grants++;
            shadow[i] = 32'h0000_0013;
            next_cycle();
        end
        n_chk++;
        if (grants !== 4) begin
            n_fail++;
            $display("FAIL boot_grants: got %0d want 4", grants);
        end
        ldr_req  = 1'b0;
        ldr_done = 1'b1;
        fetch_pc = 32'd0;
        fetch_en = 1'b1;
        @(negedge CLK);
        n_chk++;
        if (fsm_sel !== 1'b1 || ldr_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_done: got fsm_sel %b gnt %b want 1 0",
                fsm_sel, ldr_gnt);
        end
        next_cycle();
        ldr_done = 1'b0;
        @(negedge CLK);
        n_chk++;
        if ({fsm_sel, fetch_stall, mem_csn} !== 3'b110 || mem_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL release: got sel/stall/csn %b addr %0d want 110 0",
                {fsm_sel, fetch_stall, mem_csn}, mem_addr);
        end
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            fetch_pc = 32'(4 * k);
            @(negedge CLK);
            n_chk++;
            if ({fsm_sel, fetch_stall, mem_csn} !== 3'b000 || mem_addr !== 10'(k)) begin
                n_fail++;
                $display("FAIL run_fetch: got sel/stall/csn %b addr %0d want 000 %0d",
                    {fsm_sel, fetch_stall, mem_csn}, mem_addr, k);
            end
            n_chk++;
            if (mem_dout !== shadow[(k == 0) ? 0 : k - 1]) begin
                n_fail++;
                $display("FAIL run_data: got %h want %h",
                    mem_dout, shadow[(k == 0) ? 0 : k - 1]);
            end
            next_cycle();
        end
    endtask

    task automatic test_misalign();
        logic [31:0] pc;
        logic        en;
        for (int i = 0; i < 6; i++) begin
            pc       = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
            en       = 1'($urandom_range(0, 1));
            fetch_pc = pc;
            fetch_en = en;
            @(negedge CLK);
            n_chk++;
            if (fetch_misalign !== (en && pc[1:0] != 2'b00)) begin
                n_fail++;
                $display("FAIL misalign: got %b want %b pc %h en %b",
                    fetch_misalign, (en && pc[1:0] != 2'b00), pc, en);
            end
            next_cycle();
        end
        fetch_pc = 32'h0000_0040;
        fetch_en = 1'b1;
    endtask

    task automatic test_drain_read();
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 10'd5;
        ldr_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            n_chk++;
            if (fetch_stall !== (c >= 1) || ldr_gnt !== (c == 3)
                || mem_csn !== (c == 1 || c == 2)) begin
                n_fail++;
                $display("FAIL drain_c%0d: got stall %b gnt %b csn %b", c,
                    fetch_stall, ldr_gnt, mem_csn);
            end
            next_cycle();
        end
        shadow[5] = 32'hDEAD_BEEF;
        ldr_we = 1'b0;
        @(negedge CLK);
        n_chk++;
        if (ldr_gnt !== 1'b1 || ldr_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_gnt: got gnt %b rvalid %b want 1 0",
                ldr_gnt, ldr_rvalid);
        end
        next_cycle();
        ldr_req = 1'b0;
        @(negedge CLK);
        n_chk++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== shadow[5]) begin
            n_fail++;
            $display("FAIL read_data: got rvalid %b data %h want 1 %h",
                ldr_rvalid, ldr_rdata, shadow[5]);
        end
        next_cycle();
    endtask

    task automatic test_done_with_req();
        logic [9:0]  a;
        logic [31:0] d;
        a         = 10'($urandom_range(100, 199));
        d         = $urandom;
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = a;
        ldr_wdata = d;
        ldr_done  = 1'b1;
        @(negedge CLK);
        n_chk++;
        if ({ldr_gnt, mem_csn, mem_wen} !== 3'b100 || mem_addr !== a) begin
            n_fail++;
            $display("FAIL done_req: got gnt/csn/wen %b addr %0d want 100 %0d",
                {ldr_gnt, mem_csn, mem_wen}, mem_addr, a);
        end
        shadow[a] = d;
        next_cycle();
        ldr_req  = 1'b0;
        ldr_done = 1'b0;
        @(negedge CLK);
        n_chk++;
        if ({fsm_sel, fetch_stall, mem_csn, ldr_gnt} !== 4'b1100) begin
            n_fail++;
            $display("FAIL done_release: got %b want 1100",
                {fsm_sel, fetch_stall, mem_csn, ldr_gnt});
        end
        next_cycle();
        @(negedge CLK);
        n_chk++;
        if (fsm_sel !== 1'b0 || fetch_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL done_run: got sel %b stall %b want 0 0",
                fsm_sel, fetch_stall);
        end
        next_cycle();
    endtask

    task automatic test_burst();
        int k;
        int cyc;
        int run_cycles;
        k          = 0;
        cyc        = 0;
        run_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            ba[i] = 10'(200 + 8 * i + int'($urandom_range(0, 7)));
            bd[i] = $urandom;
        end
        while (k < 10 && cyc < 200) begin
            ldr_req   = 1'b1;
            ldr_we    = 1'b1;
            ldr_addr  = ba[k];
            ldr_wdata = bd[k];
            @(negedge CLK);
            if (!fetch_stall) run_cycles++;
            if (ldr_gnt) begin
                n_chk++;
                if (cyc != 3 + k + 5 * (k / 4)) begin
                    n_fail++;
                    $display("FAIL burst_timing: grant %0d at cycle %0d want %0d",
                        k, cyc, 3 + k + 5 * (k / 4));
                end
                n_chk++;
                if (mem_addr !== ba[k] || mem_wen !== 1'b0 || mem_din !== bd[k]) begin
                    n_fail++;
                    $display("FAIL burst_bus: got addr %0d wen %b din %h want %0d 0 %h",
                        mem_addr, mem_wen, mem_din, ba[k], bd[k]);
                end
                shadow[ba[k]] = bd[k];
                k++;
            end
            next_cycle();
            cyc++;
        end
        ldr_req = 1'b0;
        n_chk++;
        if (k != 10) begin
            n_fail++;
            $display("FAIL burst_count: got %0d grants want 10", k);
        end
        n_chk++;
        if (run_cycles != 5) begin
            n_fail++;
            $display("FAIL burst_run: got %0d unstalled cycles want 5", run_cycles);
        end
        return_to_run();
    endtask

    task automatic test_readback();
        logic [9:0]  ra [15];
        logic [9:0]  t;
        logic [31:0] pdata;
        bit          pend;
        int          j;
        int          k;
        int          cyc;
        for (int i = 0; i < 4; i++) ra[i] = 10'(i);
        ra[4] = 10'd5;
        for (int i = 0; i < 10; i++) ra[5 + i] = ba[i];
        for (int i = 14; i > 0; i--) begin
            j     = int'($urandom_range(0, i));
            t     = ra[i];
            ra[i] = ra[j];
            ra[j] = t;
        end
        pend  = 1'b0;
        pdata = '0;
        k     = 0;
        cyc   = 0;
        while ((k < 15 || pend) && cyc < 400) begin
            ldr_req  = (k < 15);
            ldr_we   = 1'b0;
            ldr_addr = (k < 15) ? ra[k] : 10'd0;
            @(negedge CLK);
            n_chk++;
            if (ldr_rvalid !== pend || (pend && ldr_rdata !== pdata)) begin
                n_fail++;
                $display("FAIL readback: got rvalid %b data %h want %b %h",
                    ldr_rvalid, ldr_rdata, pend, pdata);
            end
            pend = 1'b0;
            if (ldr_gnt) begin
                pend  = 1'b1;
                pdata = shadow[ra[k]];
                k++;
            end
            next_cycle();
            cyc++;
        end
        n_chk++;
        if (k != 15) begin
            n_fail++;
            $display("FAIL readback_count: got %0d reads want 15", k);
        end
        return_to_run();
    endtask

    task automatic test_reset_mid_load();
        bit got;
        got      = 1'b0;
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 10'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (ldr_gnt) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL rst_mid_gnt: no grant before reset");
        end
        next_cycle();
        RST = 1'b1;
        @(negedge CLK);
        n_chk++;
        if ({mem_csn, ldr_gnt, fsm_sel, fetch_stall, ldr_rvalid} !== 5'b10110) begin
            n_fail++;
            $display("FAIL rst_mid: got csn/gnt/sel/stall/rvalid %b want 10110",
                {mem_csn, ldr_gnt, fsm_sel, fetch_stall, ldr_rvalid});
        end
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        n_chk++;
        if ({ldr_gnt, fsm_sel, fetch_stall, mem_csn} !== 4'b1110 || mem_addr !== 10'd5) begin
            n_fail++;
            $display("FAIL rst_boot: got gnt/sel/stall/csn %b addr %0d want 1110 5",
                {ldr_gnt, fsm_sel, fetch_stall, mem_csn}, mem_addr);
        end
        next_cycle();
        ldr_req = 1'b0;
        @(negedge CLK);
        n_chk++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== shadow[5]) begin
            n_fail++;
            $display("FAIL rst_reread: got rvalid %b data %h want 1 %h",
                ldr_rvalid, ldr_rdata, shadow[5]);
        end
        next_cycle();
        return_to_run();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        mem_dout  = '0;
        ldr_done  = 1'b0;
        ldr_req   = 1'b0;
        ldr_we    = 1'b0;
        ldr_addr  = '0;
        ldr_wdata = '0;
        fetch_pc  = '0;
        fetch_en  = 1'b0;
        RST       = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            sram[i]   = '0;
            shadow[i] = '0;
        end
        test_reset();
        test_boot_load();
        test_misalign();
        test_drain_read();
        test_done_with_req();
        test_burst();
        test_readback();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end

endmodule
